sp_bram_rr_arb: RTL and testbench

Round-robin arbiter that shares one single-port block RAM (synchronous write, registered read, read-first) among G_NREQ requesters. It sits between client logic and the RAM instance, owns the RAM command port, and returns read data to the requester that issued each read. It sustains one access per cycle across all requesters, with a fixed read latency.

---
 rtl/sp_bram_rr_arb_if.sv | 29 ++
 rtl/sp_bram_rr_arb.sv | 88 ++++++++
 tb/tb_sp_bram_rr_arb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sp_bram_rr_arb_if.sv
// Bus bundle between requesters, the round-robin arbiter and the single-port RAM.
// The master side is the client/RAM environment; the slave side is the arbiter.
interface sp_bram_rr_arb_if #(
    parameter int unsigned G_NREQ  = 4,
    parameter int unsigned G_ADDR  = 6,
    parameter int unsigned G_WIDTH = 16
);
    logic [G_NREQ-1:0]         req;
    logic [G_NREQ-1:0]         req_we;
    logic [G_NREQ*G_ADDR-1:0]  req_addr;
    logic [G_NREQ*G_WIDTH-1:0] req_din;
    logic [G_NREQ-1:0]         gnt;
    logic [G_NREQ-1:0]         rvalid;
    logic [G_WIDTH-1:0]        rdata;
    logic                      ram_we;
    logic [G_ADDR-1:0]         ram_addr;
    logic [G_WIDTH-1:0]        ram_din;
    logic [G_WIDTH-1:0]        ram_dout;

    modport master (
        output req, req_we, req_addr, req_din, ram_dout,
        input  gnt, rvalid, rdata, ram_we, ram_addr, ram_din
    );

    modport slave (
        input  req, req_we, req_addr, req_din, ram_dout,
        output gnt, rvalid, rdata, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/sp_bram_rr_arb.sv
// Round-robin arbiter sharing one single-port, registered-read block RAM among
// G_NREQ requesters; one access per cycle, read data returned 2 cycles after grant.
module sp_bram_rr_arb #(
    parameter int unsigned G_NREQ  = 4,
    parameter int unsigned G_ADDR  = 6,
    parameter int unsigned G_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    sp_bram_rr_arb_if.slave bus
);
    localparam int unsigned PW = (G_NREQ > 1) ? $clog2(G_NREQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gid;
    logic               gvalid;
    logic [G_ADDR-1:0]  addr_arr [G_NREQ];
    logic [G_WIDTH-1:0] din_arr  [G_NREQ];
    logic               s1_v, s2_v;
    logic [PW-1:0]      s1_id, s2_id;

    always_comb begin
        for (int unsigned i = 0; i < G_NREQ; i++) begin
            addr_arr[i] = bus.req_addr[i*G_ADDR +: G_ADDR];
            din_arr[i]  = bus.req_din[i*G_WIDTH +: G_WIDTH];
        end
    end

    // Scan from ptr, wrapping; first asserted request wins.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        gvalid = 1'b0;
        gid    = '0;
        for (int unsigned k = 0; k < G_NREQ; k++) begin
            idx = (32'(ptr) + k) % G_NREQ;
            if (!gvalid && bus.req[idx]) begin
                gvalid = 1'b1;
                gid    = PW'(idx);
            end
        end
        if (!rst_n) begin
            gvalid = 1'b0;
        end
    end

    always_comb begin
        bus.gnt = '0;
        if (gvalid) begin
            bus.gnt[gid] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr          <= '0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            s1_v         <= 1'b0;
            s1_id        <= '0;
            s2_v         <= 1'b0;
            s2_id        <= '0;
        end else begin
            s2_v  <= s1_v;
            s2_id <= s1_id;
            s1_v  <= gvalid && !bus.req_we[gid];
            s1_id <= gid;
            if (gvalid) begin
                ptr          <= PW'((32'(gid) + 1) % G_NREQ);
                bus.ram_we   <= bus.req_we[gid];
                bus.ram_addr <= addr_arr[gid];
                bus.ram_din  <= din_arr[gid];
            end else begin
                bus.ram_we <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rvalid = '0;
        if (s2_v) begin
            bus.rvalid[s2_id] = 1'b1;
        end
    end

    assign bus.rdata = bus.ram_dout;
endmodule

// File: tb/tb_sp_bram_rr_arb.sv
// Scoreboard bench for sp_bram_rr_arb: directed requests push expected read
// returns; a negedge monitor pops and checks each rvalid strobe.
module tb_sp_bram_rr_arb;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;

    typedef struct packed {
        logic [NREQ-1:0] rv;
        logic [DW-1:0]   data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb [$];
    logic [DW-1:0] mem [64];

    sp_bram_rr_arb_if #(.G_NREQ(NREQ), .G_ADDR(AW), .G_WIDTH(DW)) bus ();

    sp_bram_rr_arb #(.G_NREQ(NREQ), .G_ADDR(AW), .G_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port RAM with registered output.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rvalid !== '0) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid: got rvalid %b, expected none at %0t", bus.rvalid, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rvalid !== e.rv || bus.rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL read_return: got rvalid %b rdata %h, expected rvalid %b rdata %h at %0t",
                             bus.rvalid, bus.rdata, e.rv, e.data, $time);
                end
            end
        end
    end

    task automatic set_req(input int i, input bit en, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]             = en;
        bus.req_we[i]          = we;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_din[i*DW +: DW]  = d;
    endtask

    task automatic clear_req();
        bus.req = '0;
    endtask

    // Check the current cycle at negedge, then advance to just after the next posedge.
    task automatic step(input logic [NREQ-1:0] exp_gnt, input int exp_ram_we,
                        input bit rd, input logic [DW-1:0] exp_data);
        exp_t e;
        @(negedge clk);
        chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
        if (exp_ram_we >= 0) chk("ram_we", 32'(bus.ram_we), 32'(exp_ram_we));
        if (rd) begin
            e.rv   = exp_gnt;
            e.data = exp_data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.req      = '0;
        bus.req_we   = '0;
        bus.req_addr = '0;
        bus.req_din  = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, '0, '0);

        // Reset held with all requests asserted.
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt",      32'(bus.gnt),      32'h0);
            chk("rst_rvalid",   32'(bus.rvalid),   32'h0);
            chk("rst_ram_we",   32'(bus.ram_we),   32'h0);
            chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0001, 0, 1'b1, 16'h0000);
        clear_req();

        // Requester 2: write BEEF @15, then read it back.
        set_req(2, 1'b1, 1'b1, 6'h15, 16'hBEEF);
        step(4'b0100, 0, 1'b0, '0);
        set_req(2, 1'b1, 1'b0, 6'h15, 16'h0000);
        step(4'b0100, 1, 1'b1, 16'hBEEF);
        clear_req();
        step(4'b0000, 0, 1'b0, '0);
        step(4'b0000, 0, 1'b0, '0);

        // Preload addresses 0..3 with 1000+i.
        for (int i = 0; i < 4; i++) begin
            clear_req();
            set_req(i, 1'b1, 1'b1, 6'(i), 16'h1000 + 16'(i));
            step(4'(1 << i), -1, 1'b0, '0);
        end
        clear_req();

        // Full contention: all requesters read their own address continuously.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 6'(i), '0);
        for (int k = 0; k < 8; k++)
            step(4'(1 << (k % 4)), (k == 0) ? 1 : 0, 1'b1, 16'h1000 + 16'(k % 4));
        clear_req();

        // Fairness with requesters 1 and 3 only.
        set_req(1, 1'b1, 1'b0, 6'h01, '0);
        set_req(3, 1'b1, 1'b0, 6'h03, '0);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) step(4'b0010, -1, 1'b1, 16'h1001);
            else            step(4'b1000, -1, 1'b1, 16'h1003);
        end
        clear_req();

        // Read-after-write: requester 0 writes 00A5 @3F, requester 1 reads it next.
        set_req(0, 1'b1, 1'b1, 6'h3F, 16'h00A5);
        set_req(1, 1'b1, 1'b0, 6'h3F, '0);
        step(4'b0001, 0, 1'b0, '0);
        bus.req[0] = 1'b0;
        step(4'b0010, 1, 1'b1, 16'h00A5);
        clear_req();
        step(4'b0000, 0, 1'b0, '0);

        // Reset mid-read: the in-flight read must never return.
        set_req(2, 1'b1, 1'b0, 6'h15, '0);
        step(4'b0100, -1, 1'b0, '0);
        clear_req();
        rst_n = 1'b0;
        step(4'b0000, 0, 1'b0, '0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(bus.rvalid), 32'h0);
            @(posedge clk);
            #1;
        end
        set_req(2, 1'b1, 1'b0, 6'h15, '0);
        step(4'b0100, 0, 1'b1, 16'hBEEF);
        clear_req();
        repeat (5) step(4'b0000, -1, 1'b0, '0);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
